// File: rtl/cmd_encoder.sv
// DDR3 command sequencer: buffers controller commands in a small FIFO and issues each as one
// active slot plus NOP slots. Optional issue counter enabled by CMD_ENCODER_STATS_EN.
module cmd_encoder #(
  parameter int unsigned ADDRESS_NUMBER = 15,
  parameter int unsigned WAIT_WIDTH     = 10,
  parameter int unsigned FIFO_LOG2      = 2
) (
  input  logic                          clk_div,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_rcw,
  input  logic [2:0]                    cmd_ba,
  input  logic [ADDRESS_NUMBER-1:0]     cmd_addr,
  input  logic                          cmd_cke,
  input  logic                          cmd_odt,
  input  logic [WAIT_WIDTH-1:0]         cmd_wait,
  output logic [2*ADDRESS_NUMBER-1:0]   out_a,
  output logic [5:0]                    out_ba,
  output logic [1:0]                    out_we,
  output logic [1:0]                    out_ras,
  output logic [1:0]                    out_cas,
  output logic [1:0]                    out_cke,
  output logic [1:0]                    out_odt,
  output logic                          out_tri,
  output logic                          idle,
  output logic [15:0]                   cmd_count
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W = FIFO_LOG2 + 1;

  typedef struct packed {
    logic [2:0]                rcw;
    logic [2:0]                ba;
    logic [ADDRESS_NUMBER-1:0] addr;
    logic                      cke;
    logic                      odt;
    logic [WAIT_WIDTH-1:0]     wait_n;
  } cmd_t;

  cmd_t                        mem_q [DEPTH];
  cmd_t                        cmd_in;
  cmd_t                        head;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WAIT_WIDTH-1:0]       wait_q, wait_d;
  logic [2*ADDRESS_NUMBER-1:0] out_a_q, out_a_d;
  logic [5:0]                  out_ba_q, out_ba_d;
  logic [1:0]                  out_we_q, out_we_d, out_ras_q, out_ras_d, out_cas_q, out_cas_d;
  logic [1:0]                  out_cke_q, out_cke_d, out_odt_q, out_odt_d;
  logic                        out_tri_q, out_tri_d;
  logic                        idle_q, idle_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        empty, push, issue;

  assign cmd_in = '{rcw: cmd_rcw, ba: cmd_ba, addr: cmd_addr, cke: cmd_cke, odt: cmd_odt,
                    wait_n: cmd_wait};
  assign head   = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // flush outranks both push and issue
  assign push   = cmd_valid & cmd_ready_q & ~flush;
  assign issue  = enable & ~empty & (wait_q == '0) & ~flush;

  // Next-state: pointers, wait counter and the two-slot output buses.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wait_d    = wait_q;
    out_a_d   = out_a_q;
    out_ba_d  = out_ba_q;
    out_cke_d = out_cke_q;
    out_odt_d = out_odt_q;
    out_ras_d = 2'b11;
    out_cas_d = 2'b11;
    out_we_d  = 2'b11;
    out_tri_d = out_tri_q;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wait_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (issue) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        out_ras_d = {1'b1, head.rcw[2]};
        out_cas_d = {1'b1, head.rcw[1]};
        out_we_d  = {1'b1, head.rcw[0]};
        out_a_d   = {head.addr, head.addr};
        out_ba_d  = {head.ba, head.ba};
        out_cke_d = {2{head.cke}};
        out_odt_d = {2{head.odt}};
        wait_d    = head.wait_n;
      end else if (wait_q != '0) begin
        wait_d = wait_q - WAIT_WIDTH'(1);
      end
    end

    // idle_q is zero whenever a wait is running, so tristate cannot assert mid-wait
    if (enable)      out_tri_d = 1'b0;
    else if (idle_q) out_tri_d = 1'b1;

    idle_d      = (wr_ptr_d == rd_ptr_d) && (wait_d == '0);
    cmd_ready_d = !((wr_ptr_d[FIFO_LOG2] != rd_ptr_d[FIFO_LOG2]) &&
                    (wr_ptr_d[FIFO_LOG2-1:0] == rd_ptr_d[FIFO_LOG2-1:0]));
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wait_q      <= '0;
      out_a_q     <= '0;
      out_ba_q    <= '0;
      out_we_q    <= 2'b11;
      out_ras_q   <= 2'b11;
      out_cas_q   <= 2'b11;
      out_cke_q   <= 2'b00;
      out_odt_q   <= 2'b00;
      out_tri_q   <= 1'b1;
      idle_q      <= 1'b1;
      cmd_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wait_q      <= wait_d;
      out_a_q     <= out_a_d;
      out_ba_q    <= out_ba_d;
      out_we_q    <= out_we_d;
      out_ras_q   <= out_ras_d;
      out_cas_q   <= out_cas_d;
      out_cke_q   <= out_cke_d;
      out_odt_q   <= out_odt_d;
      out_tri_q   <= out_tri_d;
      idle_q      <= idle_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // FIFO storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk_div) begin
    if (push) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= cmd_in;
  end

`ifdef CMD_ENCODER_STATS_EN
  logic [15:0] cmd_count_q, cmd_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    if (issue) cmd_count_d = cmd_count_q + 16'd1;
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) cmd_count_q <= '0;
    else     cmd_count_q <= cmd_count_d;
  end

  assign cmd_count = cmd_count_q;
`else
  assign cmd_count = 16'h0;
`endif

  assign out_a     = out_a_q;
  assign out_ba    = out_ba_q;
  assign out_we    = out_we_q;
  assign out_ras   = out_ras_q;
  assign out_cas   = out_cas_q;
  assign out_cke   = out_cke_q;
  assign out_odt   = out_odt_q;
  assign out_tri   = out_tri_q;
  assign idle      = idle_q;
  assign cmd_ready = cmd_ready_q;

endmodule
